// File: rtl/bench_seq_pkg.sv
// Shared types and constants for the parametrised sequential benchmark.
package bench_seq_pkg;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'b00,
        MODE_LFSR = 2'b01,
        MODE_ADD  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    function automatic logic [31:0] default_taps(input int unsigned width);
        case (width)
            16:      return TAPS_W16;
            32:      return TAPS_W32;
            default: return TAPS_W8;
        endcase
    endfunction

    // A one-update window still needs a 1-bit counter to keep the declaration legal.
    function automatic int unsigned win_cnt_w(input int unsigned window);
        return (window <= 1) ? 1 : $clog2(window);
    endfunction

endpackage

// File: rtl/bench_seq_sig_capture.sv
// Window counter plus signature register with valid/ready handoff and sticky overflow.
module bench_seq_sig_capture
    import bench_seq_pkg::*;
#(
    parameter int unsigned STATE_W = 8,
    parameter int unsigned WINDOW  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd,
    input  logic               clr,
    input  logic [STATE_W-1:0] next_state,
    input  logic               sig_ready,
    output logic [STATE_W-1:0] sig_data,
    output logic               sig_valid,
    output logic               overflow
);

    localparam int unsigned     CNT_W    = win_cnt_w(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               capture;

    always_comb begin
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        capture = upd && (cnt_q == CNT_LAST);
        if (clr) begin
            cnt_d   = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (upd) begin
                cnt_d = capture ? '0 : cnt_q + 1'b1;
            end
            if (capture) begin
                // A pending, unaccepted signature wins; the new one is dropped.
                if (valid_q && !sig_ready) begin
                    ovf_d = 1'b1;
                end else begin
                    data_d  = next_state;
                    valid_d = 1'b1;
                end
            end else if (valid_q && sig_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sig_data  = data_q;
    assign sig_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/bench_seq_param.sv
// Parametrised sequential benchmark: XOR/LFSR/ADD/HOLD state update with windowed signature.
// Optional macro BENCH_SEQ_FOLD_EN folds upper input chunks into the effective input.
module bench_seq_param
    import bench_seq_pkg::*;
#(
    parameter int unsigned        STATE_W = 8,
    parameter int unsigned        IN_W    = 12,
    parameter int unsigned        OUT_W   = 1,
    parameter logic [STATE_W-1:0] TAPS    = STATE_W'(default_taps(STATE_W)),
    parameter logic [STATE_W-1:0] SEED    = '0,
    parameter int unsigned        WINDOW  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [1:0]         mode,
    input  logic [IN_W-1:0]    in,
    output logic [OUT_W-1:0]   out,
    output logic [STATE_W-1:0] sig_data,
    output logic               sig_valid,
    input  logic               sig_ready,
    output logic               overflow
);

    localparam int unsigned NCHUNK = (IN_W + STATE_W - 1) / STATE_W;
    localparam int unsigned PAD_W  = NCHUNK * STATE_W;

    logic [PAD_W-1:0]   in_pad;
    logic [STATE_W-1:0] in_eff;
    logic [STATE_W-1:0] state_q, state_d, next_state;
    logic               upd;

    // Zero-extend to a whole number of state-width chunks.
    assign in_pad = PAD_W'(in);

`ifdef BENCH_SEQ_FOLD_EN
    always_comb begin
        in_eff = in_pad[STATE_W-1:0];
        for (int unsigned c = 1; c < NCHUNK; c++) begin
            in_eff = in_eff ^ in_pad[c*STATE_W +: STATE_W];
        end
    end
`else
    logic unused_in_hi;
    assign unused_in_hi = ^in_pad;
    assign in_eff       = in_pad[STATE_W-1:0];
`endif

    assign upd = en & ~clr;

    always_comb begin
        next_state = state_q;
        unique case (mode_e'(mode))
            MODE_XOR:  next_state = state_q ^ in_eff;
            MODE_LFSR: next_state = {state_q[STATE_W-2:0], ^(state_q & TAPS)} ^ in_eff;
            MODE_ADD:  next_state = state_q + in_eff;
            MODE_HOLD: next_state = state_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = SEED;
        end else if (upd) begin
            state_d = next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q[OUT_W-1:0];

    bench_seq_sig_capture #(
        .STATE_W (STATE_W),
        .WINDOW  (WINDOW)
    ) u_sig_capture (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd),
        .clr        (clr),
        .next_state (next_state),
        .sig_ready  (sig_ready),
        .sig_data   (sig_data),
        .sig_valid  (sig_valid),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_bench_seq_param.sv
// Self-checking bench for bench_seq_param: vector table, directed window sequences, random run.
module tb_bench_seq_param;

    localparam int unsigned STATE_W = 8;
    localparam int unsigned IN_W    = 12;
    localparam int unsigned WINDOW  = 4;
    localparam int unsigned TAPS    = 'hB8;
    localparam int unsigned SEED    = 0;

    localparam logic [1:0] MX = 2'b00;
    localparam logic [1:0] ML = 2'b01;
    localparam logic [1:0] MA = 2'b10;
    localparam logic [1:0] MH = 2'b11;

`ifdef BENCH_SEQ_FOLD_EN
    localparam logic [7:0] EXP_UPPER = 8'h55;
    localparam logic [7:0] EXP_ADD   = 8'h14;
    localparam logic [7:0] EXP_FOLD  = 8'h0F;
`else
    localparam logic [7:0] EXP_UPPER = 8'h5A;
    localparam logic [7:0] EXP_ADD   = 8'h15;
    localparam logic [7:0] EXP_FOLD  = 8'h00;
`endif

    typedef struct {
        logic        en;
        logic        clr;
        logic [1:0]  mode;
        logic [11:0] din;
        logic [7:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, clr, sig_ready;
    logic [1:0]  mode;
    logic [11:0] din;
    logic [7:0]  out, sig_data;
    logic        sig_valid, overflow;

    int total = 0;
    int bad   = 0;

    int unsigned m_state, m_cnt, m_data;
    bit          m_valid, m_ovf;

    vec_t vq[$];

    always #5 clk = ~clk;

    bench_seq_param #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W),
        .OUT_W   (8),
        .TAPS    (8'hB8),
        .SEED    (8'h00),
        .WINDOW  (WINDOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .in        (din),
        .out       (out),
        .sig_data  (sig_data),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned eff(input logic [11:0] d);
        int unsigned r;
        r = d & 'hFF;
`ifdef BENCH_SEQ_FOLD_EN
        r = r ^ (d >> 8);
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_state = SEED;
        m_cnt   = 0;
        m_data  = 0;
        m_valid = 0;
        m_ovf   = 0;
    endtask

    // Reference behaviour for one rising edge, using the inputs currently applied.
    task automatic model_edge();
        bit          cap;
        int unsigned ns;
        cap = 0;
        ns  = m_state;
        if (clr) begin
            m_state = SEED;
            m_cnt   = 0;
            m_valid = 0;
            m_ovf   = 0;
        end else begin
            if (en) begin
                case (mode)
                    MX:      ns = m_state ^ eff(din);
                    ML:      ns = (((m_state << 1) | ($countones(m_state & TAPS) % 2))
                                   ^ eff(din)) & 'hFF;
                    MA:      ns = (m_state + eff(din)) % 256;
                    default: ns = m_state;
                endcase
                m_cnt++;
                if (m_cnt == WINDOW) begin
                    m_cnt = 0;
                    cap   = 1;
                end
            end
            if (cap) begin
                if (m_valid && !sig_ready) m_ovf = 1;
                else begin
                    m_data  = ns;
                    m_valid = 1;
                end
            end else if (m_valid && sig_ready) begin
                m_valid = 0;
            end
            m_state = ns;
        end
    endtask

    task automatic check_model();
        check("model_out", out, m_state);
        check("model_sig_data", sig_data, m_data);
        check("model_sig_valid", sig_valid, m_valid);
        check("model_overflow", overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic [11:0] d);
        en   = e;
        clr  = c;
        mode = m;
        din  = d;
    endtask

    initial begin
        reset     = 1'b0;
        sig_ready = 1'b1;
        drive(1'b0, 1'b0, MX, 12'h000);
        model_reset();
        #12;
        check("reset_out", out, 8'h00);
        check("reset_valid", sig_valid, 1'b0);
        check("reset_ovf", overflow, 1'b0);
        check("reset_data", sig_data, 8'h00);
        reset = 1'b1;

        vq.push_back(vec_t'{1'b1, 1'b1, MX, 12'h000, 8'h00});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'h0A5, 8'hA5});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'h0FF, 8'h5A});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'hF00, EXP_UPPER});
        vq.push_back(vec_t'{1'b1, 1'b1, MX, 12'h0AA, 8'h00});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'h001, 8'h01});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h02});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h04});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h08});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h11});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h23});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h47});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h8E});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h1C});
        vq.push_back(vec_t'{1'b0, 1'b1, MX, 12'h000, 8'h00});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'h080, 8'h80});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h000, 8'h01});
        vq.push_back(vec_t'{1'b1, 1'b1, MA, 12'h0FF, 8'h00});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'h002, 8'h02});
        vq.push_back(vec_t'{1'b1, 1'b0, MA, 12'h0FF, 8'h01});
        vq.push_back(vec_t'{1'b0, 1'b0, MA, 12'h055, 8'h01});
        vq.push_back(vec_t'{1'b0, 1'b0, MX, 12'h055, 8'h01});
        vq.push_back(vec_t'{1'b0, 1'b0, ML, 12'h055, 8'h01});
        vq.push_back(vec_t'{1'b1, 1'b0, MH, 12'h0FF, 8'h01});
        vq.push_back(vec_t'{1'b1, 1'b0, ML, 12'h0F0, 8'hF2});
        vq.push_back(vec_t'{1'b1, 1'b0, MA, 12'h123, EXP_ADD});
        vq.push_back(vec_t'{1'b1, 1'b1, MX, 12'h000, 8'h00});
        vq.push_back(vec_t'{1'b1, 1'b0, MX, 12'hF00, EXP_FOLD});

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].clr, vq[i].mode, vq[i].din);
            step();
            check($sformatf("vec%0d_out", i), out, vq[i].exp);
        end

        // Capture while blocked, then overflow, then drain.
        sig_ready = 1'b0;
        drive(1'b0, 1'b1, MX, 12'h000);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, MX, 12'h001);
            step();
        end
        check("win_valid", sig_valid, 1'b1);
        check("win_data", sig_data, 8'h00);
        for (int i = 0; i < 4; i++) step();
        check("ovf_set", overflow, 1'b1);
        check("ovf_data_kept", sig_data, 8'h00);
        sig_ready = 1'b1;
        drive(1'b0, 1'b0, MX, 12'h000);
        step();
        check("drain_valid", sig_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Transfer and capture on the same edge.
        sig_ready = 1'b0;
        drive(1'b0, 1'b1, MX, 12'h000);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, MX, 12'h001);
            step();
        end
        drive(1'b1, 1'b0, MX, 12'h005);
        step();
        drive(1'b1, 1'b0, MX, 12'h000);
        step();
        step();
        sig_ready = 1'b1;
        step();
        check("b2b_valid", sig_valid, 1'b1);
        check("b2b_data", sig_data, 8'h05);
        check("b2b_no_ovf", overflow, 1'b0);
        drive(1'b1, 1'b0, MX, 12'h010);
        step();
        drive(1'b1, 1'b0, MX, 12'h000);
        for (int i = 0; i < 3; i++) step();
        check("b2b2_data", sig_data, 8'h15);
        check("b2b2_no_ovf", overflow, 1'b0);

        // Clear mid-window restarts the count.
        drive(1'b1, 1'b0, MX, 12'h001);
        step();
        step();
        drive(1'b1, 1'b1, MX, 12'h001);
        step();
        check("clr_out", out, 8'h00);
        check("clr_valid", sig_valid, 1'b0);
        check("clr_ovf", overflow, 1'b0);
        drive(1'b1, 1'b0, MX, 12'h001);
        for (int i = 0; i < 3; i++) step();
        check("clr_no_early_cap", sig_valid, 1'b0);
        step();
        check("clr_cap", sig_valid, 1'b1);

        // Asynchronous reset between edges with valid and overflow set.
        sig_ready = 1'b0;
        drive(1'b1, 1'b0, MX, 12'h003);
        for (int i = 0; i < 6; i++) step();
        check("pre_rst_ovf", overflow, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_out", out, 8'h00);
        check("arst_valid", sig_valid, 1'b0);
        check("arst_ovf", overflow, 1'b0);
        check("arst_data", sig_data, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 1'b0, MX, 12'h0A5);
        step();
        check("post_rst_out", out, 8'hA5);

        // Randomised run against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), ($urandom_range(15) == 0),
                  2'($urandom_range(3)), 12'($urandom));
            sig_ready = 1'($urandom_range(1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
